// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store control stage: access sizes, FSM states
// and the bytes-per-size helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // The illegal size 2'b10 maps to 4 bytes; it is rejected separately.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load result extension. The RAM already sign-extends sub-word reads, so only
// the unsigned byte/half cases need masking here.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  always_comb begin
    ext = rd;
    if (is_unsigned) begin
      case (size)
        SZ_BYTE: ext = {24'b0, rd[7:0]};
        SZ_HALF: ext = {16'b0, rd[15:0]};
        default: ext = rd;
      endcase
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of Data_RAM: one request at a time, range
// and size checks, one-cycle RAM access, held response. Optional alignment
// checking is enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [RAM_AW-1:0] ram_a,
  output logic [31:0]       ram_wd,
  output logic              ram_we,
  output logic              ram_re,
  output logic [1:0]        ram_flag,
  input  logic [31:0]       ram_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  logic [1:0]        state_q, state_d;
  logic              op_we_q;
  logic [1:0]        op_size_q;
  logic              op_unsigned_q;
  logic [RAM_AW-1:0] op_addr_q;
  logic [31:0]       op_wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              size_bad, range_bad, span_bad, align_bad, req_err;
  logic [RAM_AW:0]   last_byte;
  logic [31:0]       ext_data;
  logic              in_access;

  // The carry out of the last byte address flags an access running past the top of RAM.
  always_comb begin
    size_bad  = (req_size == 2'b10);
    range_bad = |req_addr[ADDR_W-1:RAM_AW];
    last_byte = {1'b0, req_addr[RAM_AW-1:0]}
              + (RAM_AW+1)'(size_bytes(req_size) - 3'd1);
    span_bad  = last_byte[RAM_AW];
`ifdef LSU_ALIGN_CHECK_EN
    align_bad = ((req_size == SZ_HALF) && req_addr[0])
             || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    align_bad = 1'b0;
`endif
    req_err   = size_bad | range_bad | span_bad | align_bad;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_err ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_we_q       <= 1'b0;
      op_size_q     <= 2'b00;
      op_unsigned_q <= 1'b0;
      op_addr_q     <= '0;
      op_wdata_q    <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && req_valid) begin
        op_we_q       <= req_we;
        op_size_q     <= req_size;
        op_unsigned_q <= req_unsigned;
        op_addr_q     <= req_addr[RAM_AW-1:0];
        op_wdata_q    <= req_wdata;
        rdata_q       <= '0;
        err_q         <= req_err;
      end
      if (state_q == ACCESS) begin
        rdata_q <= op_we_q ? 32'h0 : ext_data;
      end
    end
  end

  lsu_extend u_extend (
    .rd          (ram_rd),
    .size        (op_size_q),
    .is_unsigned (op_unsigned_q),
    .ext         (ext_data)
  );

  assign in_access  = (state_q == ACCESS);
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // RAM port is parked at zero outside the access cycle; reset kills a store in flight.
  assign ram_a    = in_access ? op_addr_q  : '0;
  assign ram_wd   = in_access ? op_wdata_q : '0;
  assign ram_flag = in_access ? op_size_q  : 2'b00;
  assign ram_we   = in_access & op_we_q & ~reset;
  assign ram_re   = in_access & ~op_we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array RAM stand-in, transaction-level reference
// model with per-cycle compare, and directed requests with literal expectations.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  ram_a;
  logic [31:0] ram_wd, ram_rd;
  logic        ram_we, ram_re;
  logic [1:0]  ram_flag;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .RAM_AW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .ram_a        (ram_a),
    .ram_wd       (ram_wd),
    .ram_we       (ram_we),
    .ram_re       (ram_re),
    .ram_flag     (ram_flag),
    .ram_rd       (ram_rd),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Data_RAM stand-in: byte array, combinational sign-extended read.
  logic [7:0] mem [256];
  logic [7:0] a1, a2, a3;
  assign a1 = ram_a + 8'd1;
  assign a2 = ram_a + 8'd2;
  assign a3 = ram_a + 8'd3;

  always_comb begin
    ram_rd = 32'h0;
    if (ram_re) begin
      case (ram_flag)
        2'b00:   ram_rd = {{24{mem[ram_a][7]}}, mem[ram_a]};
        2'b01:   ram_rd = {{16{mem[a1][7]}}, mem[a1], mem[ram_a]};
        default: ram_rd = {mem[a3], mem[a2], mem[a1], mem[ram_a]};
      endcase
    end
  end

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_a] = ram_wd[7:0];
      if (ram_flag != 2'b00) mem[a1] = ram_wd[15:8];
      if (ram_flag == 2'b11) begin
        mem[a2] = ram_wd[23:16];
        mem[a3] = ram_wd[31:24];
      end
    end
  end

  // Reference model: expected memory plus phase of the current transaction.
  logic [7:0]  rmem [256];
  logic        live = 1'b0;
  int          m_ph = 0;  // 0 waiting for request, 1 RAM access cycle, 2 response
  logic        x_we, x_uns, x_err;
  logic [1:0]  x_size;
  logic [31:0] x_addr, x_wdata, x_rdata;

  function automatic int unsigned nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic spec_err(input logic [1:0] s, input logic [31:0] a);
    int unsigned n = nbytes(s);
    if (s == 2'b10) return 1'b1;
    if (a > 32'd255) return 1'b1;
    if (a + n - 1 > 32'd255) return 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
    if ((a % n) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s,
                                             input logic u);
    int unsigned n = nbytes(s);
    logic [31:0] v = 32'h0;
    for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = rmem[8'(a + i)];
    if (!u && n < 4 && v[8*n-1]) begin
      for (int unsigned i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [1:0] s,
                                      input logic [31:0] d);
    for (int unsigned i = 0; i < nbytes(s); i++) rmem[8'(a + i)] = d[8*i +: 8];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ph = 0;
      live = 1'b1;
    end else if (live) begin
      case (m_ph)
        0: if (req_valid) begin
          x_we = req_we; x_size = req_size; x_uns = req_unsigned;
          x_addr = req_addr; x_wdata = req_wdata;
          if (spec_err(req_size, req_addr)) begin
            x_err = 1'b1; x_rdata = 32'h0; m_ph = 2;
          end else begin
            m_ph = 1;
          end
        end
        1: begin
          x_err = 1'b0;
          if (x_we) begin
            model_store(x_addr, x_size, x_wdata);
            x_rdata = 32'h0;
          end else begin
            x_rdata = model_load(x_addr, x_size, x_uns);
          end
          m_ph = 2;
        end
        default: if (resp_ready) m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("req_ready", req_ready, m_ph == 0);
      check("resp_valid", resp_valid, m_ph == 2);
      check("ram_we", ram_we, (m_ph == 1) && x_we && !reset);
      check("ram_re", ram_re, (m_ph == 1) && !x_we);
      check("ram_a", ram_a, (m_ph == 1) ? x_addr[7:0] : 8'h0);
      check("ram_flag", ram_flag, (m_ph == 1) ? x_size : 2'b00);
      check("ram_wd", ram_wd, (m_ph == 1) ? x_wdata : 32'h0);
      if (m_ph == 2) begin
        check("resp_rdata", resp_rdata, x_rdata);
        check("resp_err", resp_err, x_err);
      end
    end
  end

  // Issue one request from IDLE; during hold cycles a competing request is offered.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    while (lat < 0 && n < 10) begin
      @(negedge clk);
      n++;
      if (resp_valid) lat = n;
    end
    rd = resp_rdata;
    er = resp_err;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h40; req_wdata = 32'h55;
      @(negedge clk);
      check("hold resp_valid", resp_valid, 1'b1);
      check("hold req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic expect_resp(input string name, input logic [31:0] rd, input logic er,
                             input int lat, input logic [31:0] exp_rd, input logic exp_er,
                             input int exp_lat);
    check({name, " rdata"}, rd, exp_rd);
    check({name, " err"}, er, exp_er);
    check({name, " latency"}, lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i);
      rmem[i] = 8'(i);
    end
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", req_ready, 1'b1);
    check("reset resp_valid", resp_valid, 1'b0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset resp_err", resp_err, 1'b0);
    check("reset ram_we", ram_we, 1'b0);
    check("reset ram_a", ram_a, 8'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    expect_resp("sw 0x10", rd, er, lat, 32'h0, 1'b0, 2);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    expect_resp("lw 0x10", rd, er, lat, 32'hDEADBEEF, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b0, 32'h80, 32'h0, 0, rd, er, lat);
    expect_resp("lb 0x80", rd, er, lat, 32'hFFFFFF80, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b1, 32'h80, 32'h0, 0, rd, er, lat);
    expect_resp("lbu 0x80", rd, er, lat, 32'h00000080, 1'b0, 2);

    do_req(1'b1, 2'b01, 1'b0, 32'h20, 32'h1234ABCD, 0, rd, er, lat);
    expect_resp("sh 0x20", rd, er, lat, 32'h0, 1'b0, 2);
    do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0, rd, er, lat);
    expect_resp("lh 0x20", rd, er, lat, 32'hFFFFABCD, 1'b0, 2);
    do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 0, rd, er, lat);
    expect_resp("lhu 0x20", rd, er, lat, 32'h0000ABCD, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 0, rd, er, lat);
    expect_resp("lbu 0x22", rd, er, lat, 32'h00000022, 1'b0, 2);

    do_req(1'b1, 2'b11, 1'b0, 32'hFD, 32'h11223344, 0, rd, er, lat);
    expect_resp("sw 0xFD", rd, er, lat, 32'h0, 1'b1, 1);
    do_req(1'b0, 2'b00, 1'b1, 32'hFD, 32'h0, 0, rd, er, lat);
    expect_resp("lbu 0xFD", rd, er, lat, 32'h000000FD, 1'b0, 2);
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, rd, er, lat);
    expect_resp("lw 0x100", rd, er, lat, 32'h0, 1'b1, 1);
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, rd, er, lat);
    expect_resp("size 10", rd, er, lat, 32'h0, 1'b1, 1);
    do_req(1'b0, 2'b11, 1'b0, 32'hFC, 32'h0, 0, rd, er, lat);
    expect_resp("lw 0xFC", rd, er, lat, 32'hFFFEFDFC, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b1, 32'hFF, 32'h0, 0, rd, er, lat);
    expect_resp("lbu 0xFF", rd, er, lat, 32'h000000FF, 1'b0, 2);

    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 0, rd, er, lat);
`ifdef LSU_ALIGN_CHECK_EN
    expect_resp("lh 0x21", rd, er, lat, 32'h0, 1'b1, 1);
`else
    expect_resp("lh 0x21", rd, er, lat, 32'h000022AB, 1'b0, 2);
`endif

    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 5, rd, er, lat);
    expect_resp("lw backpressure", rd, er, lat, 32'hDEADBEEF, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 0, rd, er, lat);
    expect_resp("lbu 0x40", rd, er, lat, 32'h00000040, 1'b0, 2);

    // Store aborted by reset in its access cycle.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("reset-in-access ram_we", ram_we, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("after reset req_ready", req_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after reset resp_valid", resp_valid, 1'b0);
    end
    @(posedge clk); #1;
    do_req(1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 0, rd, er, lat);
    expect_resp("lw 0x30", rd, er, lat, 32'h33323130, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage between the CPU execute/memory logic and `Data_RAM`. It accepts one load or store request at a time over a valid/ready handshake and checks the address range and, optionally, alignment. It then drives the RAM port (`a`, `wd`, `we`, `re`, `flag`) for exactly one cycle, captures the read data, and applies sign or zero extension. Each request produces one response, held until the consumer accepts it.

## Interface
- `ADDR_W`, default 32: request address width.
- `RAM_AW`, default 8: RAM address width; the RAM holds 2^RAM_AW bytes.
- `clk  in  1`: the single clock. RAM writes occur on its rising edge.
- `reset  in  1`: synchronous, active-high. It is sampled on `clk` rising edge.
- `req_valid  in  1`: a request is present.
- `req_ready  out  1`: the block can accept a request. It is high only in IDLE.
- `req_we  in  1`: 1 = store, 0 = load.
- `req_size  in  2`: 00 = byte, 01 = half, 11 = word. The value 10 is illegal.
- `req_unsigned  in  1`: zero-extend the load result (lbu/lhu). It is ignored for stores and words.
- `req_addr  in  ADDR_W`: byte address.
- `req_wdata  in  32`: store data, right-aligned.
- `ram_a  out  RAM_AW`: the RAM `a` input.
- `ram_wd  out  32`: the RAM `wd` input.
- `ram_we  out  1`: the RAM `we` input.
- `ram_re  out  1`: the RAM `re` input.
- `ram_flag  out  2`: the RAM `flag` input.
- `ram_rd  in  32`: the RAM `rd` output. It is combinational, and bytes above the access size arrive already sign-extended.
- `resp_valid  out  1`: a response is available.
- `resp_ready  in  1`: the consumer accepts the response.
- `resp_rdata  out  32`: the extended load data. It is 0 for stores and errors.
- `resp_err  out  1`: the access was rejected, and the RAM was not touched.

## Operation
- States are IDLE, ACCESS and RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, the block latches all request fields and evaluates the error conditions.
  - If there is an error, it goes to RESP with `resp_err` = 1.
  - Otherwise it goes to ACCESS.
- **ACCESS** (exactly one cycle)
  - `ram_a` = `addr[RAM_AW-1:0]`.
  - `ram_flag` = size. Word is always driven as 11, never 10.
  - A store drives `ram_we` = 1 and `ram_re` = 0.
  - A load drives `ram_re` = 1, and `ram_rd` is captured into `resp_rdata` at the end of the cycle.
  - The next state is RESP.
- **RESP**
  - `resp_valid` = 1.
  - `resp_rdata` and `resp_err` are held stable.
  - On `resp_ready`, the block goes to IDLE.
- **Extension rules**
  - Unsigned byte: {24'b0, rd[7:0]}.
  - Unsigned half: {16'b0, rd[15:0]}.
  - Signed byte and signed half: RAM data unchanged.
  - Word: rd unchanged.
- **Store data** is `req_wdata` unmodified. The RAM uses only the low bytes for byte and half stores.
- **Error conditions** (any of these sets `resp_err`):
  - `req_size` = 10.
  - `addr[ADDR_W-1:RAM_AW]` is not zero.
  - `addr[RAM_AW-1:0]` + bytes − 1 > 2^RAM_AW − 1. The access must not wrap past byte 255.
  - Misalignment, when the alignment check is enabled (see Configuration).
- **Gating**
  - `ram_we` and `ram_re` are 0 outside ACCESS.
  - `ram_we` is forced to 0 while `reset` is high.
  - When no access is in progress, `ram_a`, `ram_wd` and `ram_flag` are driven to 0.

## Timing
- **Reset values**
  - State = IDLE.
  - `req_ready` = 1.
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - All `ram_*` outputs = 0.
- **Latency**
  - A request accepted at edge T drives the RAM during cycle T..T+1.
  - `resp_valid` rises after edge T+1.
  - Minimum turnaround is 3 cycles per request.
- **Error latency:** `resp_valid` rises after edge T, and no ACCESS cycle occurs.
- **Handshakes**
  - Request fields are sampled only on the edge where `req_valid` && `req_ready`.
  - `req_ready` is 0 in ACCESS and RESP, so back-to-back requests stall.
  - `resp_ready` held high gives a 1-cycle RESP.
  - `resp_ready` held low holds RESP indefinitely with stable outputs.
- **Reset during ACCESS:** the store is suppressed (`ram_we` gated), the block returns to IDLE, and no response is issued.
- **Reset during RESP:** the response is dropped.

## Configuration
- Macro: `LSU_ALIGN_CHECK_EN`.
- **Defined:**
  - A half access with addr[0] ≠ 0 is an error.
  - A word access with addr[1:0] ≠ 0 is an error.
- **Undefined:**
  - Unaligned accesses proceed to the RAM, which is byte-addressed.
  - Only the range and size checks apply.

## Structure
- Shared package `lsu_pkg` contains:
  - The size encodings: SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b11.
  - The state encoding: IDLE, ACCESS, RESP.
  - The bytes-per-size function.
- Sub-module `lsu_extend` is purely combinational. It takes rd, size and unsigned, and returns the extended data.

## Test plan
- **Word store then load:** store 0xDEADBEEF at 0x10, then load word at 0x10 → `resp_rdata` = 0xDEADBEEF, `resp_err` = 0, and `resp_valid` appears 2 cycles after accept.
- **Signed vs unsigned byte:** with RAM[0x80] = 0x80 (reset contents), lb 0x80 → 0xFFFFFF80; lbu 0x80 → 0x00000080.
- **Half:** sh 0x1234ABCD at 0x20, then lh 0x20 → 0xFFFFABCD; lhu 0x20 → 0x0000ABCD; RAM[0x22] is unchanged (0x22).
- **Error cases:**
  - Word at 0xFD gives `resp_err` = 1 with no `ram_we`/`ram_re` pulse.
  - Address 0x100 gives `resp_err` = 1.
  - Size 10 gives `resp_err` = 1.
  - With `LSU_ALIGN_CHECK_EN`, a half at 0x21 gives `resp_err` = 1; without the macro it succeeds.
- **Backpressure:**
  - With `resp_ready` = 0 for 5 cycles, `resp_valid` and data stay stable and `req_ready` stays 0.
  - A request is accepted only after `resp_ready` = 1.
- **Reset during ACCESS:** assert `reset` in the store's ACCESS cycle → no write, `resp_valid` never asserts, and `req_ready` = 1 after the edge.
